bpred_btb: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating direction counters for the 5-stage pipelined RV32 core.
- Replaces the current policy of always predicting "not taken" and flushing on every taken branch or jump.
- Lookup is combinational in the F stage and steers PCNextF.
- Update comes from the E stage. The block also flags mispredictions and keeps saturating performance counters.

---
 rtl/bpred_btb.sv | 147 ++++++++++++++
 tb/tb_bpred_btb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch-stage lookup is combinational; execute-stage resolution trains the table.
module bpred_btb #(
  parameter int WIDTH     = 32,
  parameter int IDX_BITS  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     PCF,
  output logic                 PredTakenF,
  output logic [WIDTH-1:0]     PredTargetF,
  input  logic                 UpdateE,
  input  logic                 JumpE,
  input  logic                 TakenE,
  input  logic [WIDTH-1:0]     PCE,
  input  logic [WIDTH-1:0]     PCTargetE,
  input  logic                 PredTakenE,
  input  logic [WIDTH-1:0]     PredTargetE,
  output logic                 MispredictE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_W   = WIDTH - IDX_BITS - 2;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [WIDTH-1:0]     target_q [ENTRIES];
  logic [WIDTH-1:0]     target_d [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [1:0]           ctr_d    [ENTRIES];
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0]  idx_f, idx_e;
  logic [TAG_W-1:0]     tag_f, tag_e;
  logic                 hit_f, hit_e;
  logic                 pred_taken_f;
  logic [WIDTH-1:0]     pc_plus4_f;
  logic                 mispredict_e;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign idx_f = PCF[IDX_BITS+1:2];
  assign tag_f = PCF[WIDTH-1:IDX_BITS+2];
  assign idx_e = PCE[IDX_BITS+1:2];
  assign tag_e = PCE[WIDTH-1:IDX_BITS+2];

  // Fetch-stage lookup against the pre-edge table contents (no write bypass).
  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_f = hit_f && ctr_q[idx_f][1];
    pc_plus4_f   = PCF + {{(WIDTH-3){1'b0}}, 3'd4};
    if (pred_taken_f) begin
      PredTargetF = target_q[idx_f];
    end else begin
      PredTargetF = pc_plus4_f;
    end
    PredTakenF = pred_taken_f;
  end

  // Misprediction: wrong direction, or taken with the wrong target.
  always_comb begin
    hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    mispredict_e = UpdateE &&
                   ((TakenE != PredTakenE) || (TakenE && (PredTargetE != PCTargetE)));
    MispredictE  = mispredict_e;
  end

  // Next-state table and performance counters from the resolved E-stage branch.
  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (UpdateE) begin
      branch_cnt_d = cnt_inc(branch_cnt_q);
      if (mispredict_e) begin
        mispred_cnt_d = cnt_inc(mispred_cnt_q);
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
      if (hit_e) begin
        if (JumpE) begin
          ctr_d[idx_e] = 2'd3;
        end else if (TakenE) begin
          ctr_d[idx_e] = ctr_inc(ctr_q[idx_e]);
        end else begin
          ctr_d[idx_e] = ctr_dec(ctr_q[idx_e]);
        end
        if (TakenE) begin
          target_d[idx_e] = PCTargetE;
        end else begin
          target_d[idx_e] = target_q[idx_e];
        end
      end else if (TakenE) begin
        // Allocation overwrites whatever aliased entry occupied the slot.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = PCTargetE;
        ctr_d[idx_e]    = JumpE ? 2'd3 : 2'd2;
      end else begin
        valid_d[idx_e] = valid_q[idx_e];
      end
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
  end

  // State registers; reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= {ENTRIES{1'b0}};
      branch_cnt_q  <= {CNT_WIDTH{1'b0}};
      mispred_cnt_q <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'd1;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_bpred_btb.sv
// Bench for bpred_btb: directed test-plan sequence plus randomized traffic,
// checked every cycle against a behavioural table model.
module tb_bpred_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE, JumpE, TakenE, PredTakenE;
  logic [31:0] PCE, PCTargetE, PredTargetE;
  logic        MispredictE;
  logic [3:0]  BranchCount, MispredCount;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_bc, m_mc;

  always #5 clk = ~clk;

  bpred_btb #(.WIDTH(32), .IDX_BITS(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .UpdateE(UpdateE), .JumpE(JumpE), .TakenE(TakenE),
    .PCE(PCE), .PCTargetE(PCTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  function automatic bit exp_pt(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'd15);
    return m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] exp_tgt(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'd15);
    return exp_pt(pc) ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic bit exp_mis();
    return UpdateE && ((TakenE != PredTakenE) || (TakenE && (PredTargetE != PCTargetE)));
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_update();
    int i;
    bit hit;
    if (reset) begin
      model_reset();
    end else if (UpdateE) begin
      m_bc++;
      if (exp_mis()) m_mc++;
      i   = int'((PCE >> 2) & 32'd15);
      hit = m_valid[i] && (m_tag[i] == (PCE >> 6));
      if (hit) begin
        if (JumpE) m_ctr[i] = 3;
        else if (TakenE) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        if (TakenE) m_tgt[i] = PCTargetE;
      end else if (TakenE) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = PCE >> 6;
        m_tgt[i]   = PCTargetE;
        m_ctr[i]   = JumpE ? 3 : 2;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model (pre-edge state).
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model PredTakenF", {31'd0, PredTakenF}, {31'd0, exp_pt(PCF)});
      chk("model PredTargetF", PredTargetF, exp_tgt(PCF));
      chk("model MispredictE", {31'd0, MispredictE}, {31'd0, exp_mis()});
      chk("model BranchCount", {28'd0, BranchCount}, {28'd0, sat4(m_bc)});
      chk("model MispredCount", {28'd0, MispredCount}, {28'd0, sat4(m_mc)});
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic end_cyc();
    #1 model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    end_cyc();
  endtask

  task automatic drv(input logic rst, input logic upd, input logic jmp, input logic tk,
                     input logic [31:0] pce, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt);
    reset = rst; UpdateE = upd; JumpE = jmp; TakenE = tk;
    PCE = pce; PCTargetE = tgt; PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    PCF = pcf;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tg;
    case ($urandom_range(0, 3))
      0: tg = 32'd4;
      1: tg = 32'd5;
      2: tg = 32'd9;
      default: tg = 32'h03FF_FFFF;
    endcase
    return (tg << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    model_reset();
    // 1. Cold start
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    PCF = 32'h100;
    chk_en = 1'b1;
    cyc();
    idle(32'h100);
    to_neg();
    chk("cold PredTakenF", {31'd0, PredTakenF}, 32'd0);
    chk("cold PredTargetF", PredTargetF, 32'h104);
    chk("cold BranchCount", {28'd0, BranchCount}, 32'd0);
    chk("cold MispredCount", {28'd0, MispredCount}, 32'd0);
    end_cyc();
    // 2. Allocation
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    to_neg();
    chk("alloc MispredictE", {31'd0, MispredictE}, 32'd1);
    end_cyc();
    idle(32'h100);
    to_neg();
    chk("alloc PredTakenF", {31'd0, PredTakenF}, 32'd1);
    chk("alloc PredTargetF", PredTargetF, 32'h80);
    chk("alloc BranchCount", {28'd0, BranchCount}, 32'd1);
    chk("alloc MispredCount", {28'd0, MispredCount}, 32'd1);
    end_cyc();
    // 3. Hysteresis: 2 -> 1 -> 0 -> 1 -> 2
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    cyc();
    idle(32'h100);
    to_neg();
    chk("hyst nt1 PredTakenF", {31'd0, PredTakenF}, 32'd0);
    end_cyc();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104);
    cyc();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    cyc();
    idle(32'h100);
    to_neg();
    chk("hyst t1 PredTakenF", {31'd0, PredTakenF}, 32'd0);
    end_cyc();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    cyc();
    idle(32'h100);
    to_neg();
    chk("hyst t2 PredTakenF", {31'd0, PredTakenF}, 32'd1);
    chk("hyst t2 PredTargetF", PredTargetF, 32'h80);
    end_cyc();
    // 4. Aliasing at index 0
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h140, 32'hA0, 1'b0, 32'h144);
    cyc();
    idle(32'h100);
    to_neg();
    chk("alias 0x100 PredTakenF", {31'd0, PredTakenF}, 32'd0);
    chk("alias 0x100 PredTargetF", PredTargetF, 32'h104);
    end_cyc();
    idle(32'h140);
    to_neg();
    chk("alias 0x140 PredTakenF", {31'd0, PredTakenF}, 32'd1);
    chk("alias 0x140 PredTargetF", PredTargetF, 32'hA0);
    end_cyc();
    // 5. Target change
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    cyc();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
    to_neg();
    chk("tchg MispredictE", {31'd0, MispredictE}, 32'd1);
    end_cyc();
    idle(32'h100);
    to_neg();
    chk("tchg PredTargetF", PredTargetF, 32'h90);
    end_cyc();
    idle(32'hFFFF_FFFC);
    to_neg();
    chk("wrap PredTargetF", PredTargetF, 32'h0);
    end_cyc();
    // 6. Counter saturation, then reset beating an update
    for (int k = 0; k < 10; k++) begin
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h204);
      cyc();
    end
    idle(32'h100);
    to_neg();
    chk("sat BranchCount", {28'd0, BranchCount}, 32'hF);
    chk("sat MispredCount", {28'd0, MispredCount}, 32'd7);
    end_cyc();
    drv(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h999, 1'b0, 32'h304);
    cyc();
    idle(32'h300);
    to_neg();
    chk("rstprio PredTakenF", {31'd0, PredTakenF}, 32'd0);
    chk("rstprio PredTargetF", PredTargetF, 32'h304);
    chk("rstprio BranchCount", {28'd0, BranchCount}, 32'd0);
    chk("rstprio MispredCount", {28'd0, MispredCount}, 32'd0);
    end_cyc();
    idle(32'h100);
    to_neg();
    chk("rstprio 0x100 PredTakenF", {31'd0, PredTakenF}, 32'd0);
    end_cyc();
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic jmp, tk;
      logic [31:0] pce;
      jmp = ($urandom_range(0, 3) == 0);
      tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      pce = rand_pc();
      drv(1'b0, 1'($urandom_range(0, 3) != 0), jmp, tk, pce,
          ($urandom_range(0, 1) != 0) ? (32'h1000 + ($urandom_range(0, 3) << 4)) : $urandom,
          1'b0, 32'h0);
      if ($urandom_range(0, 3) != 0) begin
        PredTakenE  = exp_pt(pce);
        PredTargetE = exp_tgt(pce);
      end else begin
        PredTakenE  = 1'($urandom_range(0, 1));
        PredTargetE = PCTargetE;
      end
      reset = ($urandom_range(0, 99) < 2);
      PCF   = rand_pc();
      cyc();
    end
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
